// File: rtl/vm80_pkg.sv
// Shared constants for the vm80 interrupt controller: RST opcode template,
// register map and command bit positions.
package vm80_pkg;

   // RST n opcode with the vector field (bits 5:3) cleared
   localparam logic [7:0] RST_OPCODE = 8'b11_000_111;

   // Register map selected by reg_addr
   typedef enum logic {
      REG_MASK = 1'b0,
      REG_CMD  = 1'b1
   } reg_addr_e;

   // Command register bit that requests a nonspecific end-of-interrupt
   localparam int EOI_BIT = 7;

   // Build the RST opcode for a 3-bit vector number
   function automatic logic [7:0] rst_op(input logic [2:0] vec);
      rst_op = RST_OPCODE | {2'b00, vec, 3'b000};
   endfunction

endpackage

// File: rtl/vm80_intc_if.sv
// Register bus between the CPU-side register decoder and the interrupt
// controller: write strobe, address, write data and combinational read data.
interface vm80_intc_if;

   logic       reg_we;
   logic       reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   modport master (
      output reg_we,
      output reg_addr,
      output reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_we,
      input  reg_addr,
      input  reg_wdata,
      output reg_rdata
   );

endinterface

// File: rtl/vm80_intc_prio.sv
// Combinational rotating priority encoder. Channel prio_ptr is the lowest
// priority, prio_ptr+1 (mod CHANNELS) the highest. A channel wins only if it
// is eligible and no in-service channel of equal or higher priority exists.
module vm80_intc_prio #(
   parameter int CHANNELS = 8,
   parameter int PW       = 3
) (
   input  logic [CHANNELS-1:0] eligible,
   input  logic [CHANNELS-1:0] isr,
   input  logic [PW-1:0]       prio_ptr,
   output logic                win_valid,
   output logic [PW-1:0]       win_ch
);

   // Walk channels from highest to lowest priority; the first in-service or eligible one ends the search
   always_comb begin
      logic          done;
      logic [PW-1:0] idx;
      win_valid = 1'b0;
      win_ch    = '0;
      done      = 1'b0;
      idx       = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         idx = PW'((int'(prio_ptr) + k) % CHANNELS);
         if (!done) begin
            if (isr[idx]) begin
               done = 1'b1;
            end else if (eligible[idx]) begin
               win_valid = 1'b1;
               win_ch    = idx;
               done      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vm80_intc.sv
// Priority interrupt controller for the KR580VM80A-compatible core.
// Latches requests, arbitrates by rotating priority and mask, injects an
// RST opcode into the fetch path and tracks in-service levels until EOI.
module vm80_intc
   import vm80_pkg::*;
#(
   parameter int CHANNELS    = 8,
   parameter int VECTOR_BASE = 0,
   parameter int EDGE        = 1,
   parameter int ROTATE      = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ce,
   input  logic [CHANNELS-1:0] irq,
   input  logic                m0,
   input  logic                iff1,
   input  logic [7:0]          mem_in,
   output logic [7:0]          cpu_in,
   output logic                inject,
   vm80_intc_if.slave          bus
);

   localparam int            PW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [PW-1:0] PTR_RESET = PW'(CHANNELS - 1);

   logic [CHANNELS-1:0] irq_p0, irq_p1, irq_p2;
   logic [CHANNELS-1:0] irq_s, rise, pend_q, pending, eligible;
   logic [CHANNELS-1:0] isr, ack, eoi_clr;
   logic [7:0]          mask;
   logic [PW-1:0]       prio_ptr, sel_ch, win_ch, top_ch;
   logic                sel_valid, win_valid, top_valid;
   logic                mask_we, eoi;
   logic [2:0]          vec;

   assign irq_s    = irq_p1;
   assign rise     = irq_s & ~irq_p2;
   assign pending  = (EDGE != 0) ? pend_q : irq_s;
   assign eligible = pending & ~mask[CHANNELS-1:0];

   assign mask_we = ce & bus.reg_we & (bus.reg_addr == REG_MASK);
   assign eoi     = ce & bus.reg_we & (bus.reg_addr == REG_CMD) & bus.reg_wdata[EOI_BIT];

   // Injection uses the registered selection, so same-cycle mask writes cannot disturb it
   assign inject = m0 & ce & iff1 & sel_valid;
   assign vec    = 3'(VECTOR_BASE) + 3'(sel_ch);
   assign cpu_in = inject ? rst_op(vec) : mem_in;

   // Arbitration winner among eligible requests
   vm80_intc_prio #(.CHANNELS(CHANNELS), .PW(PW)) u_arb (
      .eligible (eligible),
      .isr      (isr),
      .prio_ptr (prio_ptr),
      .win_valid(win_valid),
      .win_ch   (win_ch)
   );

   // Highest-priority in-service level, the target of a nonspecific EOI
   vm80_intc_prio #(.CHANNELS(CHANNELS), .PW(PW)) u_top (
      .eligible (isr),
      .isr      ({CHANNELS{1'b0}}),
      .prio_ptr (prio_ptr),
      .win_valid(top_valid),
      .win_ch   (top_ch)
   );

   // One-hot acknowledge and EOI-clear vectors
   always_comb begin
      ack     = '0;
      eoi_clr = '0;
      if (inject) ack[sel_ch] = 1'b1;
      if (eoi && top_valid) eoi_clr[top_ch] = 1'b1;
   end

   // Two-stage synchroniser, edge history and edge-latched pending; a fresh edge beats an acknowledge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq_p0 <= '0;
         irq_p1 <= '0;
         irq_p2 <= '0;
         pend_q <= '0;
      end else if (ce) begin
         irq_p0 <= irq;
         irq_p1 <= irq_p0;
         irq_p2 <= irq_p1;
         pend_q <= (pend_q & ~ack) | rise;
      end
   end

   // In-service levels: EOI clears first, then the injected level is set
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         isr <= '0;
      end else if (ce) begin
         isr <= (isr & ~eoi_clr) | ack;
      end
   end

   // Priority pointer: the channel just ended becomes lowest when rotation is enabled
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prio_ptr <= PTR_RESET;
      end else if (eoi && top_valid && (ROTATE != 0)) begin
         prio_ptr <= top_ch;
      end
   end

   // Mask register, all channels masked out of reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mask <= 8'hFF;
      end else if (mask_we) begin
         mask <= bus.reg_wdata;
      end
   end

   // Registered selection; dropped for one cycle after an injection so a request fires once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_valid <= 1'b0;
         sel_ch    <= '0;
      end else if (ce) begin
         sel_valid <= win_valid & ~inject;
         sel_ch    <= win_ch;
      end
   end

   // Combinational register read-back
   always_comb begin
      bus.reg_rdata = '0;
      if (bus.reg_addr == REG_MASK) bus.reg_rdata = mask;
      else bus.reg_rdata[CHANNELS-1:0] = pending;
   end

endmodule

// File: tb/tb_vm80_intc.sv
// Bench for vm80_intc: a rotating-priority instance and a fixed-priority
// instance share stimulus; a rank-based reference model predicts outputs
// every cycle, with directed scenarios pinning literal opcodes.
module tb_vm80_intc;

   logic       clock = 1'b0;
   logic       reset, ce, m0, iff1;
   logic [7:0] irq, mem_in;
   logic       we, addr;
   logic [7:0] wdata;
   logic [7:0] cpu_in0, cpu_in1, rdata0, rdata1;
   logic       inject0, inject1;

   vm80_intc_if bus0 ();
   vm80_intc_if bus1 ();

   assign bus0.reg_we    = we;
   assign bus0.reg_addr  = addr;
   assign bus0.reg_wdata = wdata;
   assign bus1.reg_we    = we;
   assign bus1.reg_addr  = addr;
   assign bus1.reg_wdata = wdata;
   assign rdata0 = bus0.reg_rdata;
   assign rdata1 = bus1.reg_rdata;

   always #5 clock = ~clock;

   vm80_intc #(.CHANNELS(8), .VECTOR_BASE(0), .EDGE(1), .ROTATE(1)) dut_rot (
      .clock(clock), .reset(reset), .ce(ce), .irq(irq), .m0(m0), .iff1(iff1),
      .mem_in(mem_in), .cpu_in(cpu_in0), .inject(inject0), .bus(bus0)
   );

   vm80_intc #(.CHANNELS(8), .VECTOR_BASE(0), .EDGE(1), .ROTATE(0)) dut_fix (
      .clock(clock), .reset(reset), .ce(ce), .irq(irq), .m0(m0), .iff1(iff1),
      .mem_in(mem_in), .cpu_in(cpu_in1), .inject(inject1), .bus(bus1)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Reference model state (index 0 = rotating instance, 1 = fixed)
   logic [7:0] m_h1[2], m_h2[2], m_h3[2], m_pend[2], m_isr[2], m_mask[2];
   int         m_ptr[2], m_sc[2];
   logic       m_sv[2];

   // Values sampled from the DUTs in the most recent cycle
   logic [7:0] s_cpu[2], s_rd[2];
   logic       s_inj[2];

   // Priority rank: 0 is highest, the channel at the pointer is lowest
   function automatic int rank(input int ptr, input int ch);
      return (ch - ptr - 1 + 16) % 8;
   endfunction

   function automatic int best(input logic [7:0] v, input int ptr);
      int b = -1;
      for (int ch = 0; ch < 8; ch++)
         if (v[ch] && (b < 0 || rank(ptr, ch) < rank(ptr, b))) b = ch;
      return b;
   endfunction

   function automatic logic exp_inj(input int d);
      return m0 & ce & iff1 & m_sv[d];
   endfunction

   function automatic logic [7:0] exp_cpu(input int d);
      return exp_inj(d) ? (8'hC7 | 8'((m_sc[d] % 8) << 3)) : mem_in;
   endfunction

   function automatic logic [7:0] exp_rd(input int d);
      return addr ? m_pend[d] : m_mask[d];
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_h1[d] = 0; m_h2[d] = 0; m_h3[d] = 0;
         m_pend[d] = 0; m_isr[d] = 0; m_mask[d] = 8'hFF;
         m_ptr[d] = 7; m_sv[d] = 0; m_sc[d] = 0;
      end
   endtask

   task automatic model_step();
      int w, t;
      logic wv, inj;
      logic [7:0] ack, e;
      for (int d = 0; d < 2; d++) begin
         if (ce) begin
            e   = m_pend[d] & ~m_mask[d];
            w   = best(e, m_ptr[d]);
            t   = best(m_isr[d], m_ptr[d]);
            wv  = (w >= 0) && (t < 0 || rank(m_ptr[d], w) < rank(m_ptr[d], t));
            inj = exp_inj(d);
            ack = inj ? 8'(1 << m_sc[d]) : 8'h00;
            if (we && addr && wdata[7] && t >= 0) begin
               m_isr[d][t] = 1'b0;
               if (d == 0) m_ptr[d] = t;
            end
            m_isr[d]  = m_isr[d] | ack;
            m_pend[d] = (m_pend[d] & ~ack) | (m_h2[d] & ~m_h3[d]);
            m_h3[d] = m_h2[d]; m_h2[d] = m_h1[d]; m_h1[d] = irq;
            if (we && !addr) m_mask[d] = wdata;
            m_sv[d] = wv && !inj;
            m_sc[d] = (w < 0) ? 0 : w;
         end
      end
   endtask

   // Sample both DUTs and compare against the model
   task automatic compare_all();
      s_cpu[0] = cpu_in0; s_inj[0] = inject0; s_rd[0] = rdata0;
      s_cpu[1] = cpu_in1; s_inj[1] = inject1; s_rd[1] = rdata1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("inject[%0d]", d), {7'd0, s_inj[d]}, {7'd0, exp_inj(d)});
         check($sformatf("cpu_in[%0d]", d), s_cpu[d], exp_cpu(d));
         check($sformatf("reg_rdata[%0d]", d), s_rd[d], exp_rd(d));
      end
   endtask

   // Called just after a falling edge with inputs already applied
   task automatic tick();
      #1;
      compare_all();
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
      @(negedge clock);
   endtask

   task automatic wr(input logic a, input logic [7:0] v);
      we = 1'b1; addr = a; wdata = v;
      tick();
      we = 1'b0;
   endtask

   task automatic wait_inj(input int d, input int budget, input string name, input logic [7:0] op);
      int  n = 0;
      logic seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (s_inj[d]) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 8'h00, 8'h01);
      else check(name, s_cpu[d], op);
   endtask

   initial begin
      reset = 1'b1; ce = 1'b1; irq = 8'h00; m0 = 1'b0; iff1 = 1'b1;
      mem_in = 8'h5A; we = 1'b0; addr = 1'b0; wdata = 8'h00;
      model_reset();
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset values
      addr = 1'b0; tick();
      check("rst_mask", s_rd[0], 8'hFF);
      check("rst_cpu", s_cpu[1], 8'h5A);
      addr = 1'b1; tick();
      check("rst_pend", s_rd[1], 8'h00);

      // Basic edge request on channel 3
      wr(1'b0, 8'h00);
      m0 = 1'b0; irq = 8'h08;
      repeat (3) tick();
      m0 = 1'b1; addr = 1'b1; tick();
      check("t1_pend", s_rd[1], 8'h08);
      check("t1_early", {7'd0, s_inj[1]}, 8'h00);
      tick();
      check("t1_inj", {7'd0, s_inj[1]}, 8'h01);
      check("t1_vec", s_cpu[1], 8'hDF);
      tick();
      check("t1_once", {7'd0, s_inj[1]}, 8'h00);
      check("t1_ack", s_rd[1], 8'h00);

      // Masked request, then unmask
      wr(1'b1, 8'h80);
      irq = 8'h00; repeat (3) tick();
      wr(1'b0, 8'h08);
      irq = 8'h08;
      repeat (6) begin tick(); check("t2_masked", {7'd0, s_inj[1]}, 8'h00); end
      wr(1'b0, 8'h00);
      wait_inj(1, 4, "t2_unmask", 8'hDF);

      // Nesting under in-service channel 3
      irq = 8'h28;
      repeat (6) begin tick(); check("t3_lower", {7'd0, s_inj[1]}, 8'h00); end
      irq = 8'h2A;
      wait_inj(1, 8, "t3_nest", 8'hCF);
      addr = 1'b1; tick();
      check("t3_pend", s_rd[1], 8'h20);
      wr(1'b1, 8'h80);
      wr(1'b1, 8'h7F);
      repeat (4) begin tick(); check("t3_still", {7'd0, s_inj[1]}, 8'h00); end
      wr(1'b1, 8'h80);
      wait_inj(1, 4, "t3_ch5", 8'hEF);
      wr(1'b1, 8'h80);

      // Interrupts disabled: request waits, fetch data passes through
      irq = 8'h00; repeat (3) tick();
      iff1 = 1'b0; mem_in = 8'h3E; irq = 8'h10;
      repeat (8) begin
         tick();
         check("t4_pass0", s_cpu[0], 8'h3E);
         check("t4_pass1", s_cpu[1], 8'h3E);
      end
      iff1 = 1'b1; tick();
      check("t4_inj", {7'd0, s_inj[1]}, 8'h01);
      check("t4_vec", s_cpu[1], 8'hE7);
      wr(1'b1, 8'h80);

      // Asynchronous reset in the middle of an injection cycle
      irq = 8'h00; repeat (3) tick();
      irq = 8'h01; m0 = 1'b0; repeat (5) tick();
      m0 = 1'b1; #1;
      check("t5_pre_inj", {7'd0, inject1}, 8'h01);
      check("t5_pre_vec", cpu_in1, 8'hC7);
      reset = 1'b1; irq = 8'h00; #1;
      check("t5_inj0", {7'd0, inject0}, 8'h00);
      check("t5_inj1", {7'd0, inject1}, 8'h00);
      check("t5_cpu", cpu_in1, 8'h3E);
      model_reset();
      @(posedge clock); @(negedge clock);
      reset = 1'b0; addr = 1'b1;
      repeat (8) begin tick(); check("t5_noreplay", {7'd0, s_inj[1]}, 8'h00); end
      check("t5_pend", s_rd[1], 8'h00);
      addr = 1'b0; tick();
      check("t5_mask", s_rd[1], 8'hFF);

      // Rotating priority
      wr(1'b0, 8'h00);
      irq = 8'h03;
      wait_inj(0, 8, "t6_ch0", 8'hC7);
      wr(1'b1, 8'h80);
      wait_inj(0, 4, "t6_ch1", 8'hCF);
      wr(1'b1, 8'h80);
      irq = 8'h00; repeat (3) tick();
      irq = 8'h03;
      wait_inj(0, 8, "t6_ch0_again", 8'hC7);
      wr(1'b1, 8'h80);
      wr(1'b1, 8'h80);

      // Randomised traffic checked against the model every cycle
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) irq = irq ^ 8'(1 << $urandom_range(0, 7));
         m0     = ($urandom_range(0, 2) == 0);
         iff1   = ($urandom_range(0, 7) != 0);
         ce     = ($urandom_range(0, 7) != 0);
         mem_in = 8'($urandom);
         addr   = 1'($urandom);
         we     = ($urandom_range(0, 11) == 0);
         if (addr) wdata = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
         else wdata = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         tick();
      end
      ce = 1'b1; we = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
